aes128_key_expand: RTL and testbench
====================================

// Module: aes128_key_expand
// PURPOSE
//  Sequential AES-128 key schedule feeding aes128/aes128_1 round-key inputs.
//  Expands 128-bit cipher key k into 11 round keys, one per clock, into an internal register file.
//  Random-access read port serves the encrypt path in order 0..10 and the decrypt path in order 10..0.
//  Sits directly upstream of the round datapath; lets the cipher cores drop combinational expansion.
// PARAMETERS
//  NR        10   number of rounds; fixed at 10 for AES-128, other values unsupported
//  IDX_W     4    width of round-key index
// PORTS
//  clk       in   1     single clock, rising edge
//  rst       in   1     asynchronous, active-high reset
//  start     in   1     begin expansion of k; sampled only when not busy
//  k         in   128   cipher key, FIPS-197 byte order (byte 0 = k[127:120])
//  busy      out  1     expansion in progress
//  key_ready out  1     all 11 round keys valid
//  rd_idx    in   4     round-key read index 0..10
//  rk        out  128   round key rd_idx, combinational from register file
//  rk_valid  out  1     (AES_KEYEXP_STREAM_EN only) pulse per generated key
//  rk_strm   out  128   (AES_KEYEXP_STREAM_EN only) key just generated
//  rk_sidx   out  4     (AES_KEYEXP_STREAM_EN only) index of rk_strm
// BEHAVIOUR
//  Reset (async, any time, incl. mid-expansion): FSM->IDLE, rcon=8'h01, counter=0, all 11 regfile entries 0,
//   busy=0, key_ready=0, rk_valid=0, rk_strm=0, rk_sidx=0.
//  FSM states: IDLE, EXPAND, READY.
//   IDLE/READY + start=1 at edge t: rkf[0]<=k, cnt<=1, rcon<=01, key_ready<=0, busy<=1, ->EXPAND.
//   EXPAND: each edge writes rkf[cnt] = f(rkf[cnt-1], rcon); cnt++, rcon<=xtime(rcon).
//   Edge t+10 writes rkf[10]; same edge busy<=0, key_ready<=1, ->READY. Latency: 10 cycles after start edge.
//   start while EXPAND: ignored, k not re-sampled; expansion continues unchanged.
//   READY holds key_ready=1 and regfile until next start or reset.
//  f(): w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
//   (w0 = bits 127:96). RotWord = byte left-rotate. 4 S-box lookups per cycle.
//  rcon sequence 01,02,04,08,10,20,40,80,1b,36; xtime = {r[6:0],1'b0} ^ (r[7]?8'h1b:0).
//  rk = rkf[rd_idx] at all times (valid only when key_ready=1); rd_idx 11..15 -> rk = 128'h0.
//  During EXPAND, entries 0..cnt-1 already hold final values; entries >= cnt hold stale data.
//  No key retention across start: new start overwrites rkf[0] immediately.
// CONFIGURATION
//  AES_KEYEXP_STREAM_EN defined: rk_valid=1 for one cycle after each regfile write (indices 0..10,
//   11 pulses total, back-to-back), rk_strm/rk_sidx = value/index written that edge; allows the round
//   datapath to start round 0 before key_ready. Registered outputs, same edge as regfile write.
//  Not defined: stream ports absent; only read port and key_ready exist.
// STRUCTURE
//  Package aes_pkg: NR, IDX_W, state enum {IDLE,EXPAND,READY}, function xtime, function rot_word,
//   rcon initial value localparam; shared with aes128/aes128_1.
//  Sub-module aes_sbox (8-bit forward S-box, combinational), instanced 4x for SubWord; same
//   module the cipher core uses.
// TESTING
//  Key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> busy 10 cycles; rkf[1]=a0fafe1788542cb123a339392a6c7605,
//   rkf[10]=d014f9a8c9ee2589e13f0cc8b6630ca6, key_ready=1 at edge t+10.
//  Key all-zero -> rkf[1]=62636363626363636263636362636363, rkf[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
//  start pulsed again at t+4 with different k -> ignored; final keys match first k.
//  Assert rst at t+5 -> all outputs 0 asynchronously; rd_idx=0 reads 0; new start completes normally.
//  READY, start with new k -> key_ready drops next cycle, returns at +10 with new keys; rd_idx=12 -> rk=0.
//  AES_KEYEXP_STREAM_EN: 11 consecutive rk_valid pulses, rk_sidx 0..10, rk_strm equal to read-port values.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers.
// Used by the key expander and by the aes128/aes128_1 cipher cores.
package aes_pkg;

  localparam int unsigned NR        = 10;
  localparam int unsigned IDX_W     = 4;
  localparam logic [7:0]  RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte lookup.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes128_key_expand.sv
// Sequential AES-128 key schedule: one round key per clock into an 11-entry register file.
// Optional AES_KEYEXP_STREAM_EN adds a registered stream of each key as it is written.
module aes128_key_expand
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [127:0]     k,
  output logic             busy,
  output logic             key_ready,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [127:0]     rk
`ifdef AES_KEYEXP_STREAM_EN
  ,
  output logic             rk_valid,
  output logic [127:0]     rk_strm,
  output logic [IDX_W-1:0] rk_sidx
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [7:0]       r_rcon;
  logic [127:0]     r_last;
  logic [127:0]     r_rkf [0:NR];

  logic             w_load;
  logic [31:0]      w_rot;
  logic [31:0]      w_sub;
  logic [31:0]      w_w0;
  logic [31:0]      w_w1;
  logic [31:0]      w_w2;
  logic [31:0]      w_w3;
  logic [127:0]     w_next;

  // start is only honoured outside EXPAND; a running expansion is never disturbed
  assign w_load = start && (r_state != EXPAND);

  // r_last mirrors rkf[cnt-1], so the round function never needs a wide read mux
  assign w_rot = rot_word(r_last[31:0]);

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .i_byte (w_rot[8*g +: 8]),
      .o_byte (w_sub[8*g +: 8])
    );
  end

  assign w_w0   = r_last[127:96] ^ w_sub ^ {r_rcon, 24'h0};
  assign w_w1   = r_last[95:64] ^ w_w0;
  assign w_w2   = r_last[63:32] ^ w_w1;
  assign w_w3   = r_last[31:0]  ^ w_w2;
  assign w_next = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, READY: if (start) w_state_nxt = EXPAND;
      EXPAND:      if (r_cnt == LAST_IDX) w_state_nxt = READY;
      default:     w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_rcon <= RCON_INIT;
      r_last <= '0;
      for (int unsigned i = 0; i <= NR; i++) begin
        r_rkf[i] <= '0;
      end
    end else if (w_load) begin
      r_rkf[0] <= k;
      r_last   <= k;
      r_cnt    <= IDX_W'(1);
      r_rcon   <= RCON_INIT;
    end else if (r_state == EXPAND) begin
      r_rkf[r_cnt] <= w_next;
      r_last       <= w_next;
      r_cnt        <= r_cnt + IDX_W'(1);
      r_rcon       <= xtime(r_rcon);
    end
  end

  assign busy      = (r_state == EXPAND);
  assign key_ready = (r_state == READY);

  always_comb begin
    rk = '0;
    if (rd_idx <= LAST_IDX) rk = r_rkf[rd_idx];
  end

`ifdef AES_KEYEXP_STREAM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_valid <= 1'b0;
      rk_strm  <= '0;
      rk_sidx  <= '0;
    end else if (w_load) begin
      rk_valid <= 1'b1;
      rk_strm  <= k;
      rk_sidx  <= '0;
    end else if (r_state == EXPAND) begin
      rk_valid <= 1'b1;
      rk_strm  <= w_next;
      rk_sidx  <= r_cnt;
    end else begin
      rk_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_aes128_key_expand.sv
// Directed bench for the AES-128 key expander using FIPS-197 and all-zero key vectors.
module tb_aes128_key_expand;

  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_ZERO  = 128'h0;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] k;
  logic         busy;
  logic         key_ready;
  logic [3:0]   rd_idx;
  logic [127:0] rk;
`ifdef AES_KEYEXP_STREAM_EN
  logic         rk_valid;
  logic [127:0] rk_strm;
  logic [3:0]   rk_sidx;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] fips [11];

  aes128_key_expand dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k         (k),
    .busy      (busy),
    .key_ready (key_ready),
    .rd_idx    (rd_idx),
    .rk        (rk)
`ifdef AES_KEYEXP_STREAM_EN
    ,
    .rk_valid  (rk_valid),
    .rk_strm   (rk_strm),
    .rk_sidx   (rk_sidx)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_start(input logic [127:0] key);
    @(negedge clk);
    start = 1'b1;
    k     = key;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (busy && n < 30) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; k = '0; rd_idx = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++;
    if (key_ready !== 1'b0) begin errors++; $display("FAIL reset_key_ready got %0b want 0", key_ready); end
    for (int i = 0; i <= 10; i++) begin
      rd_idx = i[3:0];
      #1;
      checks++;
      if (rk !== 128'h0) begin errors++; $display("FAIL reset_rk[%0d] got %h want 0", i, rk); end
    end
`ifdef AES_KEYEXP_STREAM_EN
    checks++;
    if (rk_valid !== 1'b0 || rk_strm !== 128'h0 || rk_sidx !== 4'h0) begin
      errors++; $display("FAIL reset_stream got %0b %h %0d want 0 0 0", rk_valid, rk_strm, rk_sidx);
    end
`endif
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fips_key;
    int n;
    do_start(KEY_FIPS);
    checks++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      errors++; $display("FAIL fips_busy_after_start got busy=%0b ready=%0b want 1 0", busy, key_ready);
    end
    wait_ready(n);
    checks++;
    if (n != 10) begin errors++; $display("FAIL fips_latency got %0d want 10", n); end
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL fips_ready got busy=%0b ready=%0b want 0 1", busy, key_ready);
    end
    for (int i = 0; i <= 10; i++) begin
      rd_idx = i[3:0];
      #1;
      checks++;
      if (rk !== fips[i]) begin errors++; $display("FAIL fips_rk[%0d] got %h want %h", i, rk, fips[i]); end
    end
  endtask

  task automatic test_start_ignored;
    int n;
    do_start(KEY_FIPS);
    repeat (3) @(negedge clk);
    rd_idx = 4'd3;
    #1;
    checks++;
    if (rk !== fips[3]) begin errors++; $display("FAIL midexp_rk3 got %h want %h", rk, fips[3]); end
    start = 1'b1;
    k     = KEY_ZERO;
    @(negedge clk);
    start = 1'b0;
    wait_ready(n);
    checks++;
    if (n != 6) begin errors++; $display("FAIL ignore_remaining_busy got %0d want 6", n); end
    for (int i = 0; i <= 10; i++) begin
      rd_idx = i[3:0];
      #1;
      checks++;
      if (rk !== fips[i]) begin errors++; $display("FAIL ignore_rk[%0d] got %h want %h", i, rk, fips[i]); end
    end
  endtask

  task automatic test_async_reset;
    int n;
    do_start(KEY_FIPS);
    repeat (4) @(negedge clk);
    rd_idx = 4'd0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || key_ready !== 1'b0) begin
      errors++; $display("FAIL arst_flags got busy=%0b ready=%0b want 0 0", busy, key_ready);
    end
    checks++;
    if (rk !== 128'h0) begin errors++; $display("FAIL arst_rk0 got %h want 0", rk); end
    rd_idx = 4'd1;
    #1;
    checks++;
    if (rk !== 128'h0) begin errors++; $display("FAIL arst_rk1 got %h want 0", rk); end
    @(negedge clk);
    rst = 1'b0;
    do_start(KEY_ZERO);
    wait_ready(n);
    checks++;
    if (n != 10 || key_ready !== 1'b1) begin
      errors++; $display("FAIL arst_restart got busy_cycles=%0d ready=%0b want 10 1", n, key_ready);
    end
    rd_idx = 4'd0;
    #1;
    checks++;
    if (rk !== KEY_ZERO) begin errors++; $display("FAIL zero_rk0 got %h want %h", rk, KEY_ZERO); end
    rd_idx = 4'd1;
    #1;
    checks++;
    if (rk !== ZERO_RK1) begin errors++; $display("FAIL zero_rk1 got %h want %h", rk, ZERO_RK1); end
    rd_idx = 4'd10;
    #1;
    checks++;
    if (rk !== ZERO_RK10) begin errors++; $display("FAIL zero_rk10 got %h want %h", rk, ZERO_RK10); end
  endtask

  task automatic test_restart_ready;
    int n;
    do_start(KEY_FIPS);
    checks++;
    if (key_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_drop got busy=%0b ready=%0b want 1 0", busy, key_ready);
    end
    wait_ready(n);
    checks++;
    if (n != 10 || key_ready !== 1'b1) begin
      errors++; $display("FAIL restart_latency got busy_cycles=%0d ready=%0b want 10 1", n, key_ready);
    end
    rd_idx = 4'd1;
    #1;
    checks++;
    if (rk !== fips[1]) begin errors++; $display("FAIL restart_rk1 got %h want %h", rk, fips[1]); end
    rd_idx = 4'd10;
    #1;
    checks++;
    if (rk !== fips[10]) begin errors++; $display("FAIL restart_rk10 got %h want %h", rk, fips[10]); end
    rd_idx = 4'd12;
    #1;
    checks++;
    if (rk !== 128'h0) begin errors++; $display("FAIL oob_rk12 got %h want 0", rk); end
    rd_idx = 4'd15;
    #1;
    checks++;
    if (rk !== 128'h0) begin errors++; $display("FAIL oob_rk15 got %h want 0", rk); end
  endtask

`ifdef AES_KEYEXP_STREAM_EN
  task automatic test_stream;
    do_start(KEY_FIPS);
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (rk_valid !== 1'b1 || rk_sidx !== i[3:0] || rk_strm !== fips[i]) begin
        errors++;
        $display("FAIL stream[%0d] got v=%0b idx=%0d key=%h want 1 %0d %h", i, rk_valid, rk_sidx, rk_strm, i, fips[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0) begin errors++; $display("FAIL stream_end got v=%0b want 0", rk_valid); end
  endtask
`endif

  initial begin
    fips[0]  = KEY_FIPS;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_fips_key();
    test_start_ignored();
    test_async_reset();
    test_restart_ready();
`ifdef AES_KEYEXP_STREAM_EN
    test_stream();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
